// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a write-pending
// scoreboard. NRD combinational read ports, one synchronous write port,
// and one reserve port that marks a register busy until write-back.
// Register 0 always reads as zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// (data and post-edge busy state) to matching read ports.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_err,
  output logic [AW:0]          pending_cnt
);

  // Count of set bits; the result never exceeds NREGS-1 because bit 0 is
  // always clear, so AW+1 bits cannot wrap.
  function automatic logic [AW:0] f_popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int k = 0; k < NREGS; k++) begin
      c = c + {{AW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_rsv_err;
  logic [AW:0]      r_pending_cnt;

  logic [NREGS-1:0] w_busy_nxt;
  logic             w_wr_valid;
  logic             w_rsv_valid;
  logic             w_rsv_err_nxt;

  assign w_wr_valid  = wr_en  && (wr_addr  != {AW{1'b0}});
  assign w_rsv_valid = rsv_en && (rsv_addr != {AW{1'b0}});

  // Next busy vector: write-back releases, then a reservation on the same
  // register re-arms it because the newly issued producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_valid) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    if (w_rsv_valid) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // A reservation on a still-pending register is an issue error, unless the
  // pending write retires on the same edge.
  always_comb begin
    w_rsv_err_nxt = 1'b0;
    if (w_rsv_valid && r_busy[rsv_addr] && !(wr_en && (wr_addr == rsv_addr))) begin
      w_rsv_err_nxt = 1'b1;
    end else begin
      w_rsv_err_nxt = 1'b0;
    end
  end

  // Storage, busy bits and registered status; async reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NREGS; j++) begin
        r_mem[j] <= {XLEN{1'b0}};
      end
      r_busy        <= {NREGS{1'b0}};
      r_rsv_err     <= 1'b0;
      r_pending_cnt <= {(AW+1){1'b0}};
    end else begin
      if (w_wr_valid) begin
        r_mem[wr_addr] <= wr_data;
      end
      r_busy        <= w_busy_nxt;
      r_rsv_err     <= w_rsv_err_nxt;
      r_pending_cnt <= f_popcount(w_busy_nxt);
    end
  end

  assign rsv_err     = r_rsv_err;
  assign pending_cnt = r_pending_cnt;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_ra = rd_addr[g*AW +: AW];

    // Read port mux: x0 is hardwired zero; optional same-cycle write forward.
    always_comb begin
      w_data = {XLEN{1'b0}};
      w_busy = 1'b0;
      if (w_ra == {AW{1'b0}}) begin
        w_data = {XLEN{1'b0}};
        w_busy = 1'b0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed while reset is held so reads stay zero.
        if (!reset && wr_en && (wr_addr == w_ra)) begin
          w_data = wr_data;
          w_busy = w_busy_nxt[w_ra];
        end else begin
          w_data = r_mem[w_ra];
          w_busy = r_busy[w_ra];
        end
`else
        w_data = r_mem[w_ra];
        w_busy = r_busy[w_ra];
`endif
      end
    end

    assign rd_data[g*XLEN +: XLEN] = w_data;
    assign rd_busy[g]              = w_busy;
  end

endmodule
